// File: rtl/pad_input_debounce.sv
// ---------------------------------------------------------------------------
// pad_input_debounce
//
// Brings one raw input-pad bit (ibuf/iobuf dataout) into the clock domain and
// removes contact bounce. The bit first goes through a synchronizer chain. A
// debounce FSM then accepts a new value only after it has been sampled for
// DEBOUNCE_CYCLES consecutive clock edges. The result is a clean registered
// level plus one-cycle rise/fall pulses.
//
// Parameters
//   SYNC_STAGES      flops in the synchronizer chain (>= 2)
//   DEBOUNCE_CYCLES  consecutive sampled cycles a new value must hold (>= 1)
//   RESET_VALUE      value of the sync chain and of level during/after reset
//
// Ports
//   clock    in   sole clock
//   reset_n  in   asynchronous, active-low reset
//   pad_in   in   raw pad value, asynchronous to clock
//   enable   in   1 = debounce active; 0 = hold level, clear counter
//   level    out  debounced, registered pad value
//   rise     out  one-cycle registered pulse on level 0->1
//   fall     out  one-cycle registered pulse on level 1->0
//   busy     out  1 while a candidate change is being counted
// ---------------------------------------------------------------------------
module pad_input_debounce #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 1000,
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic pad_in,
    input  logic enable,
    output logic level,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        STABLE   = 1'b0,
        CHANGING = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Synchronizer chain. It runs regardless of enable, so the sampled value
    // is already settled when debouncing is re-enabled.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    // NOTE: flops use non-blocking assignments so that every stage samples
    // the previous stage's value from before the edge. Blocking assignments
    // here would collapse the chain into a single flop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Debounce FSM: state register
    // -----------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_d, rise_d, fall_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            level   <= RESET_VALUE;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level   <= level_d;
            rise    <= rise_d;
            fall    <= fall_d;
        end
    end

    // -----------------------------------------------------------------------
    // Debounce FSM: next state / outputs
    // cnt counts the mismatching edges seen so far in the current candidate
    // change. The change is accepted on the edge where cnt reaches
    // DEBOUNCE_CYCLES-1, which is the DEBOUNCE_CYCLES-th mismatching edge.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        if (!enable) begin
            state_d = STABLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                STABLE: begin
                    cnt_d = '0;
                    if (s != level) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            // A single sample is enough, so accept the change immediately.
                            level_d = s;
                            rise_d  = s;
                            fall_d  = ~s;
                        end else begin
                            state_d = CHANGING;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end

                CHANGING: begin
                    if (s == level) begin
                        // Bounced back before qualifying: abandon the candidate.
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                        level_d = s;
                        rise_d  = s;
                        fall_d  = ~s;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                default: begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Decoded straight from the state flop, so busy is glitch-free and registered.
    assign busy = (state_q == CHANGING);

endmodule

// File: tb/tb_pad_input_debounce.sv
// ---------------------------------------------------------------------------
// tb_pad_input_debounce
//
// Self-checking bench for pad_input_debounce (SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, RESET_VALUE=0). The reference model delays pad_in by
// SYNC edges. It keeps a window of the most recent sampled values together
// with their enable flags. The level flips when the newest DC samples all
// differ from the current level with enable set. busy is high when a run of
// mismatching samples has started but has not yet reached DC.
// ---------------------------------------------------------------------------
module tb_pad_input_debounce;

    localparam int   SYNC = 2;
    localparam int   DC   = 4;
    localparam logic RV   = 1'b0;

    logic clock;
    logic reset_n;
    logic pad_in;
    logic enable;
    logic level;
    logic rise;
    logic fall;
    logic busy;

    int n_checks = 0;
    int n_errors = 0;

    pad_input_debounce #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DC),
        .RESET_VALUE     (RV)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .pad_in  (pad_in),
        .enable  (enable),
        .level   (level),
        .rise    (rise),
        .fall    (fall),
        .busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    logic [SYNC-1:0] dl;               // pad_in delayed by SYNC edges
    logic            hist_s  [DC-1];   // previous sampled values, [0] newest
    logic            hist_en [DC-1];
    logic            m_level, m_rise, m_fall, m_busy;

    // Length of the run of enabled samples that differ from the current level,
    // counting back from the sample taken on this edge.
    function automatic int run_len(input logic s_now, input logic en_now);
        int k;
        if (!en_now || s_now == m_level) return 0;
        k = 1;
        for (int i = 0; i < DC - 1; i++) begin
            if (hist_en[i] && hist_s[i] != m_level) k++;
            else break;
        end
        return k;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dl <= {SYNC{RV}};
            for (int i = 0; i < DC - 1; i++) begin
                hist_s[i]  <= RV;
                hist_en[i] <= 1'b0;
            end
            m_level <= RV;
            m_rise  <= 1'b0;
            m_fall  <= 1'b0;
            m_busy  <= 1'b0;
        end else begin
            dl         <= {dl[SYNC-2:0], pad_in};
            hist_s[0]  <= dl[SYNC-1];
            hist_en[0] <= enable;
            for (int i = 1; i < DC - 1; i++) begin
                hist_s[i]  <= hist_s[i-1];
                hist_en[i] <= hist_en[i-1];
            end
            if (run_len(dl[SYNC-1], enable) == DC) begin
                m_level <= dl[SYNC-1];
                m_rise  <= dl[SYNC-1];
                m_fall  <= ~dl[SYNC-1];
                m_busy  <= 1'b0;
            end else begin
                m_rise <= 1'b0;
                m_fall <= 1'b0;
                m_busy <= (run_len(dl[SYNC-1], enable) != 0);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Scenarios
    // -----------------------------------------------------------------------
    task automatic test_reset();
        int rises;
        rises   = 0;
        reset_n = 1'b0;
        pad_in  = 1'b1;
        enable  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            n_checks++;
            if ({level, rise, fall, busy} !== 4'b0000) begin
                n_errors++;
                $display("FAIL reset_hold cyc=%0d got lrfb=%b exp=0000", c, {level, rise, fall, busy});
            end
        end
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (rise) rises++;
            n_checks++;
            if ({level, rise, fall, busy} !== {m_level, m_rise, m_fall, m_busy}) begin
                n_errors++;
                $display("FAIL reset_release cyc=%0d got lrfb=%b exp=%b", c,
                         {level, rise, fall, busy}, {m_level, m_rise, m_fall, m_busy});
            end
        end
        n_checks++;
        if (rises !== 1 || level !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release_rise got rises=%0d level=%b exp rises=1 level=1", rises, level);
        end
    endtask

    task automatic test_step();
        int rises, falls, busies;
        for (int dir = 0; dir < 2; dir++) begin
            rises  = 0;
            falls  = 0;
            busies = 0;
            pad_in = (dir == 1);           // first 1->0, then 0->1
            for (int c = 0; c < 10; c++) begin
                @(negedge clock);
                if (rise) rises++;
                if (fall) falls++;
                if (busy) busies++;
                n_checks++;
                if ({level, rise, fall, busy} !== {m_level, m_rise, m_fall, m_busy}) begin
                    n_errors++;
                    $display("FAIL step dir=%0d cyc=%0d got lrfb=%b exp=%b", dir, c,
                             {level, rise, fall, busy}, {m_level, m_rise, m_fall, m_busy});
                end
            end
            n_checks++;
            if (busies !== DC - 1 || rises !== dir || falls !== 1 - dir || level !== pad_in) begin
                n_errors++;
                $display("FAIL step_summary dir=%0d got busy=%0d rise=%0d fall=%0d level=%b exp busy=%0d rise=%0d fall=%0d level=%b",
                         dir, busies, rises, falls, level, DC - 1, dir, 1 - dir, pad_in);
            end
        end
        pad_in = 1'b0;                     // leave level at 0 for the glitch test
        for (int c = 0; c < 10; c++) @(negedge clock);
    endtask

    task automatic test_glitch();
        int pulses, busies;
        pulses = 0;
        busies = 0;
        for (int c = 0; c < 12; c++) begin
            pad_in = (c < 3);
            @(negedge clock);
            if (rise || fall) pulses++;
            if (busy) busies++;
            n_checks++;
            if ({level, rise, fall, busy} !== {m_level, m_rise, m_fall, m_busy}) begin
                n_errors++;
                $display("FAIL glitch cyc=%0d got lrfb=%b exp=%b", c,
                         {level, rise, fall, busy}, {m_level, m_rise, m_fall, m_busy});
            end
        end
        n_checks++;
        if (pulses !== 0 || busies !== 3 || level !== 1'b0) begin
            n_errors++;
            $display("FAIL glitch_summary got pulses=%0d busy=%0d level=%b exp pulses=0 busy=3 level=0",
                     pulses, busies, level);
        end
    endtask

    task automatic test_bounce();
        int rises, falls;
        rises = 0;
        falls = 0;
        for (int c = 0; c < 30; c++) begin
            pad_in = (c >= 20) ? 1'b1 : ((c / 2) % 2 == 0);
            @(negedge clock);
            if (rise) rises++;
            if (fall) falls++;
            n_checks++;
            if ({level, rise, fall, busy} !== {m_level, m_rise, m_fall, m_busy}) begin
                n_errors++;
                $display("FAIL bounce cyc=%0d got lrfb=%b exp=%b", c,
                         {level, rise, fall, busy}, {m_level, m_rise, m_fall, m_busy});
            end
        end
        n_checks++;
        if (rises !== 1 || falls !== 0 || level !== 1'b1) begin
            n_errors++;
            $display("FAIL bounce_summary got rise=%0d fall=%0d level=%b exp rise=1 fall=0 level=1",
                     rises, falls, level);
        end
    endtask

    task automatic test_enable();
        int fall_at;
        fall_at = -1;
        pad_in  = 1'b0;
        enable  = 1'b1;
        for (int c = 0; c < 4; c++) begin   // 2 sync edges + 2 counting edges
            @(negedge clock);
            n_checks++;
            if ({level, rise, fall, busy} !== {m_level, m_rise, m_fall, m_busy}) begin
                n_errors++;
                $display("FAIL enable_pre cyc=%0d got lrfb=%b exp=%b", c,
                         {level, rise, fall, busy}, {m_level, m_rise, m_fall, m_busy});
            end
        end
        enable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            n_checks++;
            if ({level, rise, fall, busy} !== 4'b1000) begin
                n_errors++;
                $display("FAIL enable_off cyc=%0d got lrfb=%b exp=1000", c, {level, rise, fall, busy});
            end
        end
        enable = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (fall && fall_at < 0) fall_at = c;
            n_checks++;
            if ({level, rise, fall, busy} !== {m_level, m_rise, m_fall, m_busy}) begin
                n_errors++;
                $display("FAIL enable_on cyc=%0d got lrfb=%b exp=%b", c,
                         {level, rise, fall, busy}, {m_level, m_rise, m_fall, m_busy});
            end
        end
        n_checks++;
        if (fall_at !== DC - 1 || level !== 1'b0) begin
            n_errors++;
            $display("FAIL enable_restart got fall_at=%0d level=%b exp fall_at=%0d level=0",
                     fall_at, level, DC - 1);
        end
    endtask

    task automatic test_async_reset();
        int pulses;
        pulses = 0;
        pad_in = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            n_checks++;
            if ({level, rise, fall, busy} !== {m_level, m_rise, m_fall, m_busy}) begin
                n_errors++;
                $display("FAIL async_pre cyc=%0d got lrfb=%b exp=%b", c,
                         {level, rise, fall, busy}, {m_level, m_rise, m_fall, m_busy});
            end
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL async_midcount got busy=%b exp=1", busy);
        end
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({level, rise, fall, busy} !== 4'b0000) begin
            n_errors++;
            $display("FAIL async_instant got lrfb=%b exp=0000", {level, rise, fall, busy});
        end
        pad_in = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (rise || fall) pulses++;
            n_checks++;
            if ({level, rise, fall, busy} !== {m_level, m_rise, m_fall, m_busy}) begin
                n_errors++;
                $display("FAIL async_post cyc=%0d got lrfb=%b exp=%b", c,
                         {level, rise, fall, busy}, {m_level, m_rise, m_fall, m_busy});
            end
        end
        n_checks++;
        if (pulses !== 0 || level !== 1'b0) begin
            n_errors++;
            $display("FAIL async_no_pulse got pulses=%0d level=%b exp pulses=0 level=0", pulses, level);
        end
    endtask

    task automatic test_random();
        int hold;
        int c;
        c = 0;
        while (c < 400) begin
            pad_in = 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 7) != 0);
            hold   = int'($urandom_range(1, 8));
            for (int j = 0; j < hold; j++) begin
                @(negedge clock);
                n_checks++;
                if ({level, rise, fall, busy} !== {m_level, m_rise, m_fall, m_busy}) begin
                    n_errors++;
                    $display("FAIL random cyc=%0d got lrfb=%b exp=%b", c,
                             {level, rise, fall, busy}, {m_level, m_rise, m_fall, m_busy});
                end
                c++;
            end
        end
        enable = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1;
        pad_in  = 1'b0;
        enable  = 1'b1;
        #1;
        test_reset();
        test_step();
        test_glitch();
        test_bounce();
        test_enable();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
